frame_buffer_2p: RTL

Parametrised two-port frame buffer: the successor to the fixed 320x240x8 single-port `frame_buffer`. It takes (x,y)-addressed pixel writes from the drawing engine through a valid/ready handshake, with hardware bounds checking. It serves linear-address reads to scan-out with fixed one-cycle latency and has a built-in fill engine that clears or paints the whole frame at one pixel per cycle. It sits between the rasteriser and the display/dump path.

---
 rtl/frame_buffer_2p.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/frame_buffer_2p.sv
// frame_buffer_2p
// Two-port frame buffer of H_RES x V_RES pixels, PIX_W bits each.
//   Draw port  : (x,y)-addressed writes through a valid/ready handshake. Out-of-bounds
//                writes are dropped and counted.
//   Read port  : linear address in, registered data out one cycle later (read-first).
//   Fill engine: writes one colour to the whole frame at one pixel per cycle.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   wr_valid/wr_ready/wr_x/wr_y/wr_data  draw port
//   rd_en/rd_addr/rd_data             scan-out read port
//   fill_start/fill_color             fill request, sampled while idle
//   fill_busy/fill_done               fill status, done is a one-cycle pulse
//   oob_cnt                           saturating count of dropped draws
//
// state | meaning
// IDLE  | draw port open, waiting for fill_start
// FILL  | writing fill colour to mem[fill_cnt], one pixel per cycle
// DONE  | one-cycle fill_done pulse, draw port still closed
module frame_buffer_2p #(
    parameter  int H_RES  = 320,
    parameter  int V_RES  = 240,
    parameter  int PIX_W  = 8,
    localparam int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [15:0]       wr_x,
    input  logic [15:0]       wr_y,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              fill_start,
    input  logic [PIX_W-1:0]  fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [15:0]       oob_cnt
);
    localparam int                N      = H_RES * V_RES;
    localparam int                PROD_W = 16 + $clog2(H_RES);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  fill_cnt;
    logic [PIX_W-1:0]   fill_val;

    logic               ws_valid;
    logic [ADDR_W-1:0]  ws_addr;
    logic [PIX_W-1:0]   ws_data;

    logic [PIX_W-1:0]   mem [N];

    logic [PROD_W-1:0]  lin_addr;
    logic               in_bounds;
    logic               wr_fire;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_wa;
    logic [PIX_W-1:0]   mem_wd;

    // Gating on fill_start combinationally guarantees a draw never lands during a fill.
    assign wr_ready  = (state == IDLE) && !fill_start;
    assign wr_fire   = wr_valid && wr_ready;
    assign in_bounds = (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES);
    // Full-width product; only narrowed after the bounds check has qualified it.
    assign lin_addr  = PROD_W'(wr_y) * PROD_W'(H_RES) + PROD_W'(wr_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            fill_val  <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        state     <= FILL;
                        fill_val  <= fill_color;
                        fill_cnt  <= '0;
                        fill_busy <= 1'b1;
                    end
                end
                FILL: begin
                    if (fill_cnt == LAST) begin
                        state     <= DONE;
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    fill_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_valid <= 1'b0;
            ws_addr  <= '0;
            ws_data  <= '0;
            oob_cnt  <= '0;
        end else begin
            ws_valid <= wr_fire && in_bounds;
            if (wr_fire && in_bounds) begin
                ws_addr <= ADDR_W'(lin_addr);
                ws_data <= wr_data;
            end
            if (wr_fire && !in_bounds && (oob_cnt != 16'hFFFF)) begin
                oob_cnt <= oob_cnt + 16'd1;
            end
        end
    end

    // Single write port shared by fill and draw; they are never active together.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (state == FILL) begin
            mem_we = 1'b1;
            mem_wa = fill_cnt;
            mem_wd = fill_val;
        end else if (ws_valid) begin
            mem_we = 1'b1;
            mem_wa = ws_addr;
            mem_wd = ws_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Reads see the pre-edge contents, giving read-first behaviour on collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (32'(rd_addr) < N) ? mem[rd_addr] : '0;
        end
    end
endmodule
